// File: rtl/instr_encoder_loader.sv
// Packs RV32I instruction fields into 32-bit words and streams them into instruction memory.
// Optional macro ENC_IMM_CHECK_EN drops bundles whose immediate does not fit its format.
module instr_encoder_loader #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = 256,
   localparam int         CW          = $clog2(DEPTH_WORDS) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          finish,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [6:0]    opcode,
   input  logic [2:0]    func3,
   input  logic [6:0]    func7,
   input  logic [4:0]    rd,
   input  logic [4:0]    rs1,
   input  logic [4:0]    rs2,
   input  logic [31:0]   immediate,
   output logic          imem_we,
   output logic [31:0]   imem_addr,
   output logic [31:0]   imem_wdata,
   output logic [CW-1:0] word_count,
   output logic          full,
   output logic          err
);
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_IMM  = 7'b0010011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_AUI  = 7'b0010111;
   localparam logic [6:0] OP_J    = 7'b1101111;

   typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;
   state_t state;

   logic [31:0] enc;
   logic        supported, imm_ok, is_shift, accept, xfer;

   assign is_shift = (opcode == OP_IMM) && (func3 == 3'b001 || func3 == 3'b101);

   always_comb begin
      enc       = '0;
      supported = 1'b1;
      case (opcode)
         OP_R:                     enc = {func7, rs2, rs1, func3, rd, opcode};
         OP_IMM, OP_LOAD, OP_JALR: enc = {(is_shift ? {func7, immediate[4:0]} : immediate[11:0]),
                                          rs1, func3, rd, opcode};
         OP_S:                     enc = {immediate[11:5], rs2, rs1, func3, immediate[4:0], opcode};
         OP_B:                     enc = {immediate[12], immediate[10:5], rs2, rs1, func3,
                                          immediate[4:1], immediate[11], opcode};
         OP_LUI, OP_AUI:           enc = {immediate[31:12], rd, opcode};
         OP_J:                     enc = {immediate[20], immediate[10:1], immediate[11],
                                          immediate[19:12], rd, opcode};
         default:                  supported = 1'b0;
      endcase
   end

`ifdef ENC_IMM_CHECK_EN
   // A signed value fits N bits when every bit above N-1 matches the sign bit.
   always_comb begin
      imm_ok = 1'b1;
      case (opcode)
         OP_IMM, OP_LOAD, OP_JALR:
            imm_ok = is_shift ? (immediate[31:5] == '0)
                              : (&immediate[31:11] | ~|immediate[31:11]);
         OP_S:   imm_ok = &immediate[31:11] | ~|immediate[31:11];
         OP_B:   imm_ok = (&immediate[31:12] | ~|immediate[31:12]) & ~immediate[0];
         OP_J:   imm_ok = (&immediate[31:20] | ~|immediate[31:20]) & ~immediate[0];
         default: imm_ok = 1'b1;
      endcase
   end
`else
   assign imm_ok = 1'b1;
`endif

   assign in_ready = (state == LOAD) & ~start & ~finish;
   assign xfer     = in_valid & in_ready;
   assign accept   = supported & imm_ok;

   // imem_addr shows the address of the word being written; it steps once that write has issued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         imem_we    <= 1'b0;
         imem_addr  <= BASE_ADDR;
         imem_wdata <= '0;
         word_count <= '0;
         full       <= 1'b0;
         err        <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         if (start) begin
            state      <= LOAD;
            imem_addr  <= BASE_ADDR;
            word_count <= '0;
            full       <= 1'b0;
            err        <= 1'b0;
         end else begin
            if (imem_we) imem_addr <= imem_addr + 32'd4;
            if (xfer) begin
               if (accept) begin
                  imem_we    <= 1'b1;
                  imem_wdata <= enc;
                  word_count <= word_count + CW'(1);
                  if (word_count + CW'(1) == CW'(DEPTH_WORDS)) begin
                     state <= FULL;
                     full  <= 1'b1;
                  end
               end else begin
                  err <= 1'b1;
               end
            end else if (finish && state == LOAD) begin
               state <= IDLE;
            end
         end
      end
   end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: randomized bundles checked against a field-level reference model.
module tb_instr_encoder_loader;
   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0, reset = 1'b0;
   logic          start = 1'b0, finish = 1'b0, in_valid = 1'b0, in_ready;
   logic [6:0]    opcode = '0, func7 = '0;
   logic [2:0]    func3 = '0;
   logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
   logic [31:0]   immediate = '0;
   logic          imem_we, full, err;
   logic [31:0]   imem_addr, imem_wdata;
   logic [CW-1:0] word_count;

   instr_encoder_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .func3(func3),
      .func7(func7), .rd(rd), .rs1(rs1), .rs2(rs2), .immediate(immediate),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .word_count(word_count), .full(full), .err(err));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {logic [31:0] addr; logic [31:0] data; int cyc;} wr_t;
   wr_t exp_q[$];
   wr_t mon_e;
   int tests = 0, fails = 0;

   // reference model state: 0 idle, 1 loading, 2 full
   int          m_state = 0, m_count = 0;
   logic [31:0] m_addr = BASE;
   bit          m_err = 0, m_full = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] f(input logic [31:0] v, input int sh, input int bits);
      return ((v >> sh) & ((32'd1 << bits) - 32'd1));
   endfunction

   function automatic bit ref_enc(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                  input logic [31:0] imm, output logic [31:0] w);
      logic [31:0] base_rs, field;
      int  s;
      bit  shift;
      s       = $signed(imm);
      shift   = (op == 7'h13) && (f3 == 3'd1 || f3 == 3'd5);
      base_rs = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
      w = '0;
      case (op)
         7'h33: w = (32'(f7) << 25) | (32'(s2) << 20) | base_rs | (32'(d) << 7);
         7'h13, 7'h03, 7'h67: begin
            field = shift ? (32'(f7) * 32 + f(imm, 0, 5)) : f(imm, 0, 12);
            w = (field << 20) | base_rs | (32'(d) << 7);
         end
         7'h23: w = (f(imm, 5, 7) << 25) | (32'(s2) << 20) | base_rs | (f(imm, 0, 5) << 7);
         7'h63: w = (f(imm, 12, 1) << 31) | (f(imm, 5, 6) << 25) | (32'(s2) << 20) | base_rs
                    | (f(imm, 1, 4) << 8) | (f(imm, 11, 1) << 7);
         7'h37, 7'h17: w = (imm & 32'hFFFF_F000) | (32'(d) << 7) | 32'(op);
         7'h6F: w = (f(imm, 20, 1) << 31) | (f(imm, 1, 10) << 21) | (f(imm, 11, 1) << 20)
                    | (f(imm, 12, 8) << 12) | (32'(d) << 7) | 32'(op);
         default: return 1'b0;
      endcase
`ifdef ENC_IMM_CHECK_EN
      case (op)
         7'h13, 7'h03, 7'h67:
            if (shift ? (imm >= 32) : (s < -2048 || s > 2047)) return 1'b0;
         7'h23: if (s < -2048 || s > 2047) return 1'b0;
         7'h63: if (s < -4096 || s > 4094 || imm[0]) return 1'b0;
         7'h6F: if (s < -(1 << 20) || s > (1 << 20) - 2 || imm[0]) return 1'b0;
         default: ;
      endcase
`endif
      return 1'b1;
   endfunction

   always @(negedge clk) begin
      if (!reset && imem_we) begin
         if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", imem_addr, mon_e.addr);
            chk("wr_data", imem_wdata, mon_e.data);
            chk("wr_cycle", cyc, mon_e.cyc);
         end
      end
   end

   task automatic step(input bit st, input bit fin, input bit vld, input logic [6:0] op,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] imm,
                       input bit use_lit, input logic [31:0] lit);
      bit          exp_rdy, ok;
      logic [31:0] w;
      start = st; finish = fin; in_valid = vld; opcode = op; func3 = f3; func7 = f7;
      rd = d; rs1 = s1; rs2 = s2; immediate = imm;
      exp_rdy = (m_state == 1) && !st && !fin;
      @(negedge clk);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("word_count", 32'(word_count), 32'(m_count));
      chk("full", 32'(full), 32'(m_full));
      chk("err", 32'(err), 32'(m_err));
      if (!imem_we) chk("addr_idle", imem_addr, m_addr);
      if (st) begin
         m_state = 1; m_count = 0; m_addr = BASE; m_err = 0; m_full = 0;
      end else if (vld && exp_rdy) begin
         ok = ref_enc(op, f3, f7, d, s1, s2, imm, w);
         if (ok) begin
            exp_q.push_back('{m_addr, use_lit ? lit : w, cyc + 1});
            m_addr += 32'd4;
            m_count++;
            if (m_count == DEPTH) begin m_state = 2; m_full = 1; end
         end else m_err = 1;
      end else if (fin && m_state == 1) m_state = 0;
      @(posedge clk); #1;
   endtask

   task automatic idle();
      step(0, 0, 0, '0, '0, '0, '0, '0, '0, '0, 0, '0);
   endtask
   task automatic do_start();
      step(1, 0, 0, '0, '0, '0, '0, '0, '0, '0, 0, '0);
   endtask
   task automatic bundle(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [31:0] imm, input logic [31:0] lit);
      step(0, 0, 1, op, f3, f7, d, s1, s2, imm, 1, lit);
   endtask

   task automatic do_reset();
      reset = 1; start = 0; finish = 0; in_valid = 0;
      exp_q.delete();
      m_state = 0; m_count = 0; m_addr = BASE; m_err = 0; m_full = 0;
      @(negedge clk);
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_addr", imem_addr, BASE);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk("rst_count", 32'(word_count), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_flags", {30'd0, full, err}, 32'd0);
      @(posedge clk); #1;
      reset = 0;
   endtask

   logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};

   initial begin
      logic [31:0] imm;
      #1;
      do_reset();
      // single R-type word
      do_start();
      bundle(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3);
      idle(); idle();
      // back-to-back fill to DEPTH, fifth bundle must be held
      do_start();
      bundle(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093);
      bundle(7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423);
      bundle(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 32'h008000EF);
      bundle(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7);
      bundle(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093);
      idle();
      do_start(); idle();
      // unsupported opcode is dropped and flagged
      bundle(7'h7F, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0);
      idle();
      bundle(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3);
      idle(); do_start(); idle();
      // addi with a 4096 immediate: truncated, or rejected when checking is enabled
      bundle(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 32'h00000093);
      idle();
      // reset during the write cycle discards the write
      do_start();
      bundle(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3);
      do_reset();
      idle();
      // finish returns to IDLE and blocks further bundles
      do_start();
      bundle(7'h13, 3'd5, 7'h20, 5'd4, 5'd4, 5'd0, 32'd3, 32'h40325213);
      step(0, 1, 1, 7'h33, '0, '0, 5'd1, 5'd1, 5'd1, '0, 0, '0);
      bundle(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3);
      idle();
      // randomized traffic against the reference model
      for (int i = 0; i < 500; i++) begin
         case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: imm = (32'($urandom_range(0, 1 << 21)) - 32'd1048576) & ~32'd1;
            default: imm = 32'($urandom_range(0, 40));
         endcase
         step($urandom_range(0, 11) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7,
              ops[$urandom_range(0, 9)], 3'($urandom), 7'($urandom), 5'($urandom),
              5'($urandom), 5'($urandom), imm, 0, '0);
      end
      idle(); idle();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
